// File: rtl/cic_decimator.sv
// CIC (sinc^ORDER) decimator for a 1-bit delta-sigma bitstream.
// Supports a one-shot incremental conversion (final integrator value) and a
// continuous mode (free-running integrators followed by combs), with a
// runtime-selectable power-of-two decimation ratio.
module cic_decimator #(
  parameter int ORDER     = 2,
  parameter int MAX_RLOG2 = 8,
  parameter int ACC_W     = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             mode,
  input  logic [3:0]       r_log2,
  input  logic             din,
  input  logic             din_valid,
  output logic [ACC_W-1:0] dout,
  output logic             dout_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_INC  = 2'd1,
    RUN_CONT = 2'd2
  } state_t;

  localparam logic [MAX_RLOG2:0] CNT_ONE   = 1;
  localparam logic [2:0]         WARM_DONE = 3'(ORDER);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [3:0]         rlog2_q, rlog2_d;
  logic [ACC_W-1:0]   integ_q [ORDER];
  logic [ACC_W-1:0]   integ_d [ORDER];
  logic [ACC_W-1:0]   dly_q   [ORDER];
  logic [ACC_W-1:0]   dly_d   [ORDER];
  logic [MAX_RLOG2:0] cnt_q, cnt_d;
  logic [2:0]         warm_q, warm_d;
  logic [ACC_W-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;

  // Integrator values after accepting the current sample, and comb chain taps.
  logic [ACC_W-1:0]   integ_upd [ORDER];
  logic [ACC_W-1:0]   comb_c    [ORDER+1];

  logic [3:0]         rl_eff;
  logic [MAX_RLOG2:0] cnt_wrap;
  logic               last_sample;
  logic               abort;

  // Out-of-range ratios (0 or above MAX_RLOG2) fall back to the largest ratio.
  assign rl_eff      = (rlog2_q == 4'd0 || rlog2_q > 4'(MAX_RLOG2)) ? 4'(MAX_RLOG2) : rlog2_q;
  assign cnt_wrap    = (CNT_ONE << rl_eff) - CNT_ONE;
  assign last_sample = (cnt_q == cnt_wrap);
  // Any change of the configuration captured at entry, or dropping en, aborts.
  assign abort       = !en || (mode != mode_q) || (r_log2 != rlog2_q);

  // Integrator cascade uses already-updated lower stages; combs difference
  // successive decimated values of the last integrator.
  always_comb begin
    integ_upd[0] = integ_q[0] + ACC_W'(din);
    for (int k = 1; k < ORDER; k++) begin
      integ_upd[k] = integ_q[k] + integ_upd[k-1];
    end
    comb_c[0] = integ_upd[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_c[k+1] = comb_c[k] - dly_q[k];
    end
  end

  // Next-state, datapath update and output strobe.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    rlog2_d      = rlog2_q;
    integ_d      = integ_q;
    dly_d        = dly_q;
    cnt_d        = cnt_q;
    warm_d       = warm_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && (mode || start)) begin
          state_d = mode ? RUN_CONT : RUN_INC;
          mode_d  = mode;
          rlog2_d = r_log2;
          integ_d = '{default: '0};
          dly_d   = '{default: '0};
          cnt_d   = '0;
          warm_d  = '0;
        end
      end

      RUN_INC, RUN_CONT: begin
        if (abort || (state_q == RUN_INC && start)) begin
          // Abort leaves dout alone; a start in RUN_INC restarts the count.
          state_d = abort ? IDLE : RUN_INC;
          integ_d = '{default: '0};
          dly_d   = '{default: '0};
          cnt_d   = '0;
          warm_d  = '0;
        end else if (din_valid) begin
          integ_d = integ_upd;
          cnt_d   = last_sample ? '0 : cnt_q + CNT_ONE;
          if (last_sample) begin
            if (state_q == RUN_INC) begin
              dout_d       = integ_upd[ORDER-1];
              dout_valid_d = 1'b1;
              state_d      = IDLE;
            end else begin
              for (int k = 0; k < ORDER; k++) begin
                dly_d[k] = comb_c[k];
              end
              dout_d = comb_c[ORDER];
              // The first ORDER outputs still contain the startup transient.
              if (warm_q == WARM_DONE) begin
                dout_valid_d = 1'b1;
              end else begin
                warm_d = warm_q + 3'd1;
              end
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      rlog2_q      <= '0;
      integ_q      <= '{default: '0};
      dly_q        <= '{default: '0};
      cnt_q        <= '0;
      warm_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rlog2_q      <= rlog2_d;
      integ_q      <= integ_d;
      dly_q        <= dly_d;
      cnt_q        <= cnt_d;
      warm_q       <= warm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cic_decimator.sv
// Randomised bench for cic_decimator. The reference model keeps the accepted
// bitstream and evaluates the filter in closed form: the ORDER-fold running
// sum is a binomially weighted sum of the inputs, and the continuous output
// is the ORDER-th backward difference of that sum at decimation instants.
module tb_cic_decimator;
  localparam int ORDER     = 2;
  localparam int MAX_RLOG2 = 8;
  localparam int ACC_W     = 17;
  localparam longint MASK  = (64'd1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             reset, en, start, mode, din, din_valid;
  logic [3:0]       r_log2;
  logic [ACC_W-1:0] dout;
  logic             dout_valid, busy;

  always #5 clk = ~clk;

  cic_decimator #(.ORDER(ORDER), .MAX_RLOG2(MAX_RLOG2), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .mode(mode),
    .r_log2(r_log2), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          running;
  bit          run_cont;
  int          r_len;
  bit          xs[$];
  logic [31:0] exp_dout;
  int          cyc;
  int          last_pulse;
  int          want_gap;

  function automatic longint binom(int n, int k);
    longint r = 1;
    if (k < 0 || k > n) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // ORDER-fold cumulative sum of the first t accepted samples, mod 2^ACC_W.
  function automatic longint integ_n(int t);
    longint acc = 0;
    for (int s = 1; s <= t; s++)
      if (xs[s-1]) acc = (acc + binom(t - s + ORDER - 1, ORDER - 1)) & MASK;
    return acc;
  endfunction

  // m-th decimated continuous output: ORDER-th difference of integ_n at multiples of R.
  function automatic longint cont_out(int m);
    longint acc = 0;
    longint term;
    for (int j = 0; j <= ORDER; j++) begin
      if (m - j > 0) begin
        term = binom(ORDER, j) * integ_n((m - j) * r_len);
        acc  = (j % 2 == 1) ? acc - term : acc + term;
      end
    end
    return acc & MASK;
  endfunction

  // One clock: drive at negedge, observe just after posedge, update model, compare.
  task automatic cycle(input bit d, input bit v, input bit st);
    bit ev;
    bit ev_valid;
    int m;
    ev = 0;
    ev_valid = 0;
    @(negedge clk);
    din = d; din_valid = v; start = st;
    @(posedge clk);
    #1;
    cyc++;
    if (running && !run_cont && st) begin
      xs.delete();
    end else if (running && v) begin
      xs.push_back(d);
      if (xs.size() % r_len == 0) begin
        ev = 1;
        if (!run_cont) begin
          exp_dout = 32'(integ_n(r_len));
          ev_valid = 1;
          running  = 0;
        end else begin
          m        = xs.size() / r_len;
          exp_dout = 32'(cont_out(m));
          ev_valid = (m > ORDER);
        end
      end
    end
    if (ev || dout_valid) begin
      check("dout_valid", 32'(dout_valid), 32'(ev_valid));
      check("dout", 32'(dout), exp_dout);
      $display("cyc=%0d out dout=%0d valid=%0d exp=%0d", cyc, dout, dout_valid, exp_dout);
    end
    if (dout_valid && want_gap > 0) begin
      if (last_pulse >= 0) check("pulse_gap", 32'(cyc - last_pulse), 32'(want_gap));
      last_pulse = cyc;
    end
  endtask

  task automatic begin_run(input bit md, input logic [3:0] rl);
    int rl_eff;
    @(negedge clk);
    en = 1; mode = md; r_log2 = rl; start = !md;
    din = 1'($urandom); din_valid = 1;
    @(posedge clk);
    #1;
    cyc++;
    rl_eff   = (rl == 0 || rl > MAX_RLOG2) ? MAX_RLOG2 : int'(rl);
    r_len    = 1 << rl_eff;
    running  = 1;
    run_cont = md;
    xs.delete();
    check("busy_entry", 32'(busy), 1);
  endtask

  // kind: 0 ones, 1 alternating, 2 random, 3 first only, 4 last only.
  // gap: idle cycles before each sample, -1 for random 0..3.
  task automatic run_samples(input int n, input int kind, input int gap);
    bit d;
    int g;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       d = 1;
        1:       d = (i % 2 == 0);
        2:       d = 1'($urandom);
        3:       d = (i == 0);
        default: d = (i == n - 1);
      endcase
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) cycle(1'($urandom), 1'b0, 1'b0);
      cycle(d, 1'b1, 1'b0);
    end
  endtask

  // Abort a run by dropping en; dout must hold and no pulse may appear.
  task automatic stop_run(input string tag);
    @(negedge clk);
    en = 0; din_valid = 1; din = 1;
    @(posedge clk);
    #1;
    cyc++;
    running = 0;
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid"}, 32'(dout_valid), 0);
    check({tag, "_dout"}, 32'(dout), exp_dout);
  endtask

  initial begin
    reset = 1; en = 0; start = 0; mode = 0; r_log2 = 4'd4; din = 0; din_valid = 0;
    running = 0; run_cont = 0; r_len = 16; exp_dout = 0; cyc = 0;
    last_pulse = -1; want_gap = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_busy", 32'(busy), 0);

    // Incremental conversions, R=16.
    begin_run(0, 4'd4); run_samples(16, 0, 0);  check("inc_ones", 32'(dout), 136);
    check("inc_busy_done", 32'(busy), 0);
    begin_run(0, 4'd4); run_samples(16, 3, -1); check("inc_first", 32'(dout), 16);
    begin_run(0, 4'd4); run_samples(16, 4, -1); check("inc_last", 32'(dout), 1);
    for (int t = 0; t < 3; t++) begin
      begin_run(0, 4'd4); run_samples(16, 2, -1);
    end
    begin_run(0, 4'd3); run_samples(8, 2, 0);
    // Clamped ratio: 12 behaves as 8 -> R=256, all ones gives 256*257/2.
    begin_run(0, 4'd12); run_samples(256, 0, 0); check("inc_clamp", 32'(dout), 32896);

    // Continuous, R=16.
    begin_run(1, 4'd4); run_samples(96, 0, 0); check("cont_dc", 32'(dout), 256);
    stop_run("cont_stop");
    begin_run(1, 4'd4); run_samples(96, 1, 0); check("cont_alt", 32'(dout), 128);
    stop_run("alt_stop");
    want_gap = 48; last_pulse = -1;
    begin_run(1, 4'd4); run_samples(96, 0, 2); check("cont_gap_dc", 32'(dout), 256);
    want_gap = 0;
    stop_run("gap_stop");
    begin_run(1, 4'd2); run_samples(64, 2, -1);
    stop_run("rand_stop");

    // Abort by toggling mode mid-incremental.
    begin_run(0, 4'd4); run_samples(5, 0, 0);
    @(negedge clk);
    mode = 1; din_valid = 1; din = 1;
    @(posedge clk);
    #1;
    cyc++;
    running = 0;
    check("abort_mode_busy", 32'(busy), 0);
    check("abort_mode_valid", 32'(dout_valid), 0);
    check("abort_mode_dout", 32'(dout), exp_dout);
    @(negedge clk);
    en = 0; mode = 0;
    // Abort by dropping en mid-incremental.
    begin_run(0, 4'd4); run_samples(9, 2, 0);
    stop_run("abort_en");
    // Restart mid-incremental: only the 16 samples after the restart count.
    begin_run(0, 4'd4); run_samples(7, 0, 0);
    cycle(1'b1, 1'b1, 1'b1);
    run_samples(15, 0, 0);
    check("restart_busy", 32'(busy), 1);
    run_samples(1, 0, 0);
    check("restart_dout", 32'(dout), 136);
    stop_run("restart_idle");

    // Long continuous run, R=256: integrators wrap, output stays at 65536.
    begin_run(1, 4'd8); run_samples(40 * 256, 0, 0);
    check("long_dc", 32'(dout), 65536);
    run_samples(100, 0, 0);
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    check("async_rst_dout", 32'(dout), 0);
    check("async_rst_valid", 32'(dout_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    running = 0; exp_dout = 0;
    @(negedge clk);
    reset = 0; en = 0; din_valid = 0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("post_rst_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
